// File: rtl/alu_iter.sv
// Execute-stage ALU.
// ADD/SUB/AND/ORR/EOR complete in a single cycle. MUL is an iterative
// radix-2 shift-add multiplier that takes WIDTH cycles.
// A Start/Busy/Done handshake lets the datapath stall while a MUL runs.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | ready; Start is accepted, single-cycle ops complete here
// S_MUL  | shift-add multiply in progress; Busy=1, Start is ignored

module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [WIDTH-1:0] ALUResult,
  output logic [3:0]       Flags,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_ORR = 3'b011;
  localparam logic [2:0] OP_EOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;
  logic             r_done;

  logic             w_busy;
  logic             w_is_mul;
  logic             w_mul_last;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_op_res;
  logic             w_op_c;
  logic             w_op_v;
  logic [3:0]       w_op_flags;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic: MUL runs for exactly WIDTH edges after acceptance
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (Start && w_is_mul) w_state_nxt = S_MUL;
      S_MUL:  if (w_mul_last)        w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs and multiply-step helpers
  always_comb begin
    w_busy     = (r_state == S_MUL);
    w_is_mul   = (ALUControl == OP_MUL);
    w_mul_last = (r_count == CW'(WIDTH - 1));
    w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : '0);
  end

  // Single-cycle result and NZCV; SUB reuses the adder as A + ~B + 1
  always_comb begin
    w_b_eff  = SrcB;
    w_cin    = 1'b0;
    if (ALUControl == OP_SUB) begin
      w_b_eff = ~SrcB;
      w_cin   = 1'b1;
    end
    w_sum    = {1'b0, SrcA} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin};
    w_op_res = '0;
    w_op_c   = 1'b0;
    w_op_v   = 1'b0;
    case (ALUControl)
      OP_ADD: begin
        w_op_res = w_sum[WIDTH-1:0];
        w_op_c   = w_sum[WIDTH];
        w_op_v   = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (w_op_res[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OP_SUB: begin
        w_op_res = w_sum[WIDTH-1:0];
        w_op_c   = w_sum[WIDTH];
        w_op_v   = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (w_op_res[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OP_AND:  w_op_res = SrcA & SrcB;
      OP_ORR:  w_op_res = SrcA | SrcB;
      OP_EOR:  w_op_res = SrcA ^ SrcB;
      default: w_op_res = '0;
    endcase
    w_op_flags = {w_op_res[WIDTH-1], (w_op_res == '0), w_op_c, w_op_v};
  end

  // Datapath: capture on acceptance, iterate the multiplier, publish results
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      r_result <= '0;
      r_flags  <= 4'b0000;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (Start) begin
          if (w_is_mul) begin
            r_acc    <= '0;
            r_count  <= '0;
            r_mcand  <= SrcA;
            r_mplier <= SrcB;
          end else begin
            r_result <= w_op_res;
            r_flags  <= w_op_flags;
            r_done   <= 1'b1;
          end
        end
      end else begin
        r_acc    <= w_acc_nxt;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_count  <= r_count + CW'(1);
        if (w_mul_last) begin
          r_result <= w_acc_nxt;
          r_flags  <= {w_acc_nxt[WIDTH-1], (w_acc_nxt == '0), 2'b00};
          r_done   <= 1'b1;
        end
      end
    end
  end

  assign ALUResult = r_result;
  assign Flags     = r_flags;
  assign Busy      = w_busy;
  assign Done      = r_done;

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter: table-driven single-cycle ops plus
// hand-written multi-cycle MUL, back-to-back and mid-MUL reset sequences.

module tb_alu_iter;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [2:0]  ALUControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [31:0] ALUResult;
  logic [3:0]  Flags;
  logic        Busy;
  logic        Done;

  int checks   = 0;
  int failures = 0;

  alu_iter #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .Start     (Start),
    .ALUControl(ALUControl),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .ALUResult (ALUResult),
    .Flags     (Flags),
    .Busy      (Busy),
    .Done      (Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flg;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    Start      = st;
    ALUControl = c;
    SrcA       = a;
    SrcB       = b;
  endtask

  // Start a MUL at a negedge and wait (bounded) for Done; checks latency and result.
  task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic [3:0] exp_flg);
    int k;
    int done_at;
    drive(1'b1, 3'b101, a, b);
    @(negedge clk);
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    done_at = -1;
    for (k = 0; k <= 40; k++) begin
      if (Done && done_at < 0) done_at = k;
      if (done_at >= 0) break;
      @(negedge clk);
    end
    chk({name, "_latency"}, done_at, 32);
    chk({name, "_res"}, ALUResult, exp_res);
    chk({name, "_flags"}, {28'h0, Flags}, {28'h0, exp_flg});
    @(negedge clk);
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    int done_at;

    vecs[0]  = '{"add_wrap",   3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110};
    vecs[1]  = '{"sub_borrow", 3'b001, 32'd5,         32'd7,         32'hFFFF_FFFE, 4'b1000};
    vecs[2]  = '{"sub_pos",    3'b001, 32'd7,         32'd5,         32'h0000_0002, 4'b0010};
    vecs[3]  = '{"add_ovf",    3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001};
    vecs[4]  = '{"and",        3'b010, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 4'b0000};
    vecs[5]  = '{"orr",        3'b011, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 4'b0000};
    vecs[6]  = '{"eor_zero",   3'b100, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'h0000_0000, 4'b0100};
    vecs[7]  = '{"rsvd110",    3'b110, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 4'b0100};
    vecs[8]  = '{"sub_eq",     3'b001, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0110};
    vecs[9]  = '{"sub_ovf",    3'b001, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011};
    vecs[10] = '{"add_negovf", 3'b000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 4'b0111};

    reset = 1'b1;
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_res",   ALUResult, 32'h0);
    chk("rst_flags", {28'h0, Flags}, 32'h0);
    chk("rst_busy",  {31'h0, Busy}, 32'h0);
    chk("rst_done",  {31'h0, Done}, 32'h0);

    // Single-cycle vectors: Done the cycle after acceptance, then Done drops and the result holds.
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, vecs[i].ctrl, vecs[i].a, vecs[i].b);
      @(negedge clk);
      drive(1'b0, 3'b000, 32'h1234_5678, 32'h1111_1111);
      chk({vecs[i].name, "_done"},  {31'h0, Done}, 32'h1);
      chk({vecs[i].name, "_res"},   ALUResult, vecs[i].res);
      chk({vecs[i].name, "_flags"}, {28'h0, Flags}, {28'h0, vecs[i].flg});
      @(negedge clk);
      chk({vecs[i].name, "_done_low"}, {31'h0, Done}, 32'h0);
      chk({vecs[i].name, "_hold"},     ALUResult, vecs[i].res);
    end

    // Back-to-back: second op issued on the first op's Done cycle.
    drive(1'b1, 3'b000, 32'h7FFF_FFFF, 32'h0000_0001);
    @(negedge clk);
    chk("b2b_done1",  {31'h0, Done}, 32'h1);
    chk("b2b_res1",   ALUResult, 32'h8000_0000);
    chk("b2b_flags1", {28'h0, Flags}, 32'h9);
    drive(1'b1, 3'b100, 32'hF0F0_F0F0, 32'hF0F0_F0F0);
    @(negedge clk);
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    chk("b2b_done2",  {31'h0, Done}, 32'h1);
    chk("b2b_res2",   ALUResult, 32'h0);
    chk("b2b_flags2", {28'h0, Flags}, 32'h4);
    @(negedge clk);
    chk("b2b_done_low", {31'h0, Done}, 32'h0);

    // MUL with ignored ADD Starts while busy and operand changes after acceptance.
    drive(1'b1, 3'b101, 32'h0001_0000, 32'h0001_0001);
    @(negedge clk);
    drive(1'b0, 3'b000, 32'hDEAD_BEEF, 32'h0000_0003);
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    for (int k = 0; k <= 40; k++) begin
      if (Busy) busy_cnt++;
      if (Done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (k == 5 || k == 20 || k == 30) drive(1'b1, 3'b000, 32'h0000_0001, 32'h0000_0001);
      else drive(1'b0, 3'b000, 32'hDEAD_BEEF, 32'h0000_0003);
      if (k == 31) drive(1'b0, 3'b000, 32'h0, 32'h0);
      @(negedge clk);
    end
    chk("mul_busy_cycles", busy_cnt, 32);
    chk("mul_done_at",     done_at, 32);
    chk("mul_done_count",  done_cnt, 1);
    chk("mul_res",         ALUResult, 32'h0001_0000);
    chk("mul_flags",       {28'h0, Flags}, 32'h0);

    run_mul("mul_neg",  32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 4'b1000);
    run_mul("mul_sq",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0000);
    run_mul("mul_zero", 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 4'b0100);

    // Asynchronous reset 10 cycles into a MUL.
    drive(1'b1, 3'b101, 32'd3, 32'd5);
    @(negedge clk);
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    repeat (9) @(negedge clk);
    chk("mulrst_busy_before", {31'h0, Busy}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("mulrst_busy",  {31'h0, Busy}, 32'h0);
    chk("mulrst_done",  {31'h0, Done}, 32'h0);
    chk("mulrst_res",   ALUResult, 32'h0);
    chk("mulrst_flags", {28'h0, Flags}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_res", ALUResult, 32'h0);
    drive(1'b1, 3'b011, 32'h0000_000F, 32'h0000_00F0);
    @(negedge clk);
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    chk("post_rst_orr_done",  {31'h0, Done}, 32'h1);
    chk("post_rst_orr_res",   ALUResult, 32'h0000_00FF);
    chk("post_rst_orr_flags", {28'h0, Flags}, 32'h0);
    repeat (40) @(negedge clk);
    chk("post_rst_no_done", {31'h0, Done}, 32'h0);
    chk("post_rst_idle",    {31'h0, Busy}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
